// File: rtl/mult_pkg.sv
// ---------------------------------------------------------------------------
// mult_pkg
//   Shared constants and types for the 8-bit sequential multiplier.
//   W       operand width
//   PROD_W  product width (2*W)
//   CNT_W   width of the bit-position counter used during CALC
//   state_e FSM state encoding (IDLE -> CALC -> DONE -> IDLE)
//   pp()    partial product: operand shifted to bit position idx when the
//           selected multiplier bit is set, zero otherwise
// ---------------------------------------------------------------------------
package mult_pkg;

  localparam int W      = 8;
  localparam int PROD_W = 2 * W;
  localparam int CNT_W  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Zero-extend first so the shift cannot drop high bits.
  function automatic logic [PROD_W-1:0] pp(input logic [W-1:0]     mcand,
                                           input logic [W-1:0]     mplier,
                                           input logic [CNT_W-1:0] idx);
    logic [PROD_W-1:0] ext;
    ext = {{(PROD_W-W){1'b0}}, mcand};
    pp  = mplier[idx] ? (ext << idx) : '0;
  endfunction

endpackage

// File: rtl/seg_scan.sv
// ---------------------------------------------------------------------------
// seg_scan
//   Free-running one-hot digit-select scanner for an 8-digit display.
//   A divider counts 0..SEG_DIV-1; each time it wraps, the one-hot select
//   rotates left by one bit (bit7 wraps to bit0).
// Ports
//   clk           in   system clock, rising edge
//   rst           in   synchronous active-high reset
//   seg_position  out  one-hot digit select, 8'b0000_0001 after reset
// Parameters
//   SEG_DIV       clocks per step, >= 1
// ---------------------------------------------------------------------------
module seg_scan #(
  parameter int SEG_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] seg_position
);

  // Keep at least one divider bit so SEG_DIV=1 still elaborates cleanly.
  localparam int DIV_W = (SEG_DIV > 1) ? $clog2(SEG_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SEG_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [7:0]       seg_q, seg_d;
  logic             wrap;

  assign wrap = (div_q == DIV_MAX);

  always_comb begin
    div_d = div_q;
    seg_d = seg_q;
    if (wrap) begin
      div_d = '0;
      seg_d = {seg_q[6:0], seg_q[7]};
    end else begin
      div_d = div_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
      seg_q <= 8'b0000_0001;
    end else begin
      div_q <= div_d;
      seg_q <= seg_d;
    end
  end

  assign seg_position = seg_q;

endmodule

// File: rtl/mult8_top.sv
// ---------------------------------------------------------------------------
// mult8_top
//   8x8 unsigned shift-and-add multiplier. Operands are captured in IDLE
//   when start is high, the 16-bit product is accumulated over 8 CALC
//   clocks, and DONE publishes it on d_out with a one-cycle done_flag.
//   Timeline from the capture edge E0: CALC edges E1..E8, done_flag and
//   d_out update at E9, done_flag drops at E10 (back in IDLE), earliest
//   next capture at E11.
// Ports
//   clk           in   system clock, rising edge
//   rst           in   synchronous active-high reset, highest priority
//   start         in   level request, sampled only in IDLE
//   a, b          in   operands; ignored unless captured in IDLE
//   locked        out  1 while captured operands are being multiplied
//   d_out         out  last product, held until the next DONE
//   done_flag     out  one-cycle pulse when d_out is refreshed
//   seg_position  out  one-hot display digit select
//   verif_a/b     out  operands as captured, held until the next capture
// Parameters
//   SEG_DIV       clocks per seg_position step (ports fixed at W=8)
// ---------------------------------------------------------------------------
module mult8_top
  import mult_pkg::*;
#(
  parameter int SEG_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [W-1:0]      a,
  input  logic [W-1:0]      b,
  output logic              locked,
  output logic [PROD_W-1:0] d_out,
  output logic              done_flag,
  output logic [7:0]        seg_position,
  output logic [W-1:0]      verif_a,
  output logic [W-1:0]      verif_b
);

  state_e            state_q,     state_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;
  logic [PROD_W-1:0] acc_q,       acc_d;
  logic [W-1:0]      verif_a_q,   verif_a_d;
  logic [W-1:0]      verif_b_q,   verif_b_d;
  logic              locked_q,    locked_d;
  logic [PROD_W-1:0] d_out_q,     d_out_d;
  logic              done_flag_q, done_flag_d;

  // ---- next-state / datapath ---------------------------------------------
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    verif_a_d   = verif_a_q;
    verif_b_d   = verif_b_q;
    locked_d    = locked_q;
    d_out_d     = d_out_q;
    done_flag_d = done_flag_q;

    unique case (state_q)
      IDLE: begin
        // a/b are only looked at here, so a floating source while locked
        // can never leak into the registers.
        if (start) begin
          verif_a_d = a;
          verif_b_d = b;
          acc_d     = '0;
          cnt_d     = '0;
          locked_d  = 1'b1;
          state_d   = CALC;
        end
      end

      CALC: begin
        acc_d = acc_q + pp(verif_a_q, verif_b_q, cnt_q);
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(W - 1)) begin
          state_d = DONE;
        end
      end

      DONE: begin
        // DONE spans two edges: the first publishes the result, the second
        // (seen via done_flag_q) retires the pulse and returns to IDLE.
        if (!done_flag_q) begin
          d_out_d     = acc_q;
          done_flag_d = 1'b1;
          locked_d    = 1'b0;
        end else begin
          done_flag_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d     = IDLE;
        locked_d    = 1'b0;
        done_flag_d = 1'b0;
      end
    endcase
  end

  // ---- state registers ---------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      verif_a_q   <= '0;
      verif_b_q   <= '0;
      locked_q    <= 1'b0;
      d_out_q     <= '0;
      done_flag_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      verif_a_q   <= verif_a_d;
      verif_b_q   <= verif_b_d;
      locked_q    <= locked_d;
      d_out_q     <= d_out_d;
      done_flag_q <= done_flag_d;
    end
  end

  assign locked    = locked_q;
  assign d_out     = d_out_q;
  assign done_flag = done_flag_q;
  assign verif_a   = verif_a_q;
  assign verif_b   = verif_b_q;

  // ---- display scanner, independent of the multiplier --------------------
  seg_scan #(
    .SEG_DIV(SEG_DIV)
  ) u_seg_scan (
    .clk         (clk),
    .rst         (rst),
    .seg_position(seg_position)
  );

endmodule

// File: tb/tb_mult8_top.sv
module tb_mult8_top;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  a, b;
  logic        locked;
  logic [15:0] d_out;
  logic        done_flag;
  logic [7:0]  seg_position;
  logic [7:0]  verif_a, verif_b;

  int errors = 0;
  int checks = 0;
  logic [15:0] last_prod;

  always #5 clk = ~clk;

  mult8_top #(.SEG_DIV(4)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .locked(locked), .d_out(d_out), .done_flag(done_flag),
    .seg_position(seg_position), .verif_a(verif_a), .verif_b(verif_b)
  );

  // Advance one rising edge and settle before sampling / driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = 8'hA5; b = 8'h5A;
    tick(); tick();
    checks++;
    if (locked !== 1'b0 || done_flag !== 1'b0 || d_out !== 16'd0 ||
        verif_a !== 8'd0 || verif_b !== 8'd0 || seg_position !== 8'h01) begin
      errors++;
      $display("FAIL reset: locked=%b done=%b d_out=%0d va=%0d vb=%0d seg=%h, want 0 0 0 0 0 01",
               locked, done_flag, d_out, verif_a, verif_b, seg_position);
    end
    rst = 1'b0;
    last_prod = 16'd0;
  endtask

  // One full transaction from IDLE. mode: 0 hold a/b, 1 random a/b while
  // locked, 2 float a/b while locked. Returns in IDLE right after the pulse.
  task automatic run_mult(input logic [7:0] xa, input logic [7:0] xb, input int mode,
                          input string tag);
    logic [15:0] exp;
    int n;
    bit seen;
    exp = 16'(xa) * 16'(xb);
    a = xa; b = xb; start = 1'b1;
    tick();  // E0
    checks++;
    if (locked !== 1'b1 || verif_a !== xa || verif_b !== xb) begin
      errors++;
      $display("FAIL %s capture: locked=%b va=%0d vb=%0d, want 1 %0d %0d",
               tag, locked, verif_a, verif_b, xa, xb);
    end
    start = 1'b0;
    n = 0; seen = 0;
    while (n < 20 && !seen) begin
      if (mode == 1) begin a = 8'($urandom); b = 8'($urandom); end
      if (mode == 2) begin a = 8'bz; b = 8'bz; end
      tick(); n++;
      if (done_flag === 1'b1) seen = 1;
      else if (n == 8) begin
        checks++;
        if (d_out !== last_prod || locked !== 1'b1) begin
          errors++;
          $display("FAIL %s hold_before_done: d_out=%0d locked=%b, want %0d 1",
                   tag, d_out, locked, last_prod);
        end
      end
    end
    checks++;
    if (!seen || n != 9) begin
      errors++;
      $display("FAIL %s latency: done after %0d clocks (seen=%0d), want 9", tag, n, seen);
    end
    checks++;
    if (d_out !== exp || verif_a !== xa || verif_b !== xb || locked !== 1'b0) begin
      errors++;
      $display("FAIL %s result: d_out=%0d va=%0d vb=%0d locked=%b, want %0d %0d %0d 0",
               tag, d_out, verif_a, verif_b, locked, exp, xa, xb);
    end
    tick();  // E10
    checks++;
    if (done_flag !== 1'b0 || d_out !== exp || verif_a !== xa || verif_b !== xb) begin
      errors++;
      $display("FAIL %s pulse_end: done=%b d_out=%0d va=%0d vb=%0d, want 0 %0d %0d %0d",
               tag, done_flag, d_out, verif_a, verif_b, exp, xa, xb);
    end
    last_prod = exp;
  endtask

  task automatic test_directed();
    run_mult(8'd129, 8'd19,  0, "m129x19");
    run_mult(8'd255, 8'd255, 0, "m255x255");
    run_mult(8'd0,   8'd200, 0, "m0x200");
    run_mult(8'd1,   8'd1,   0, "m1x1");
    run_mult(8'd200, 8'd128, 1, "locked_change");
    run_mult(8'd77,  8'd201, 2, "locked_float");
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      int gap;
      run_mult(8'($urandom), 8'($urandom), int'($urandom_range(0, 2)), "random");
      gap = int'($urandom_range(0, 3));
      a = 8'($urandom); b = 8'($urandom);
      for (int g = 0; g < gap; g++) tick();
    end
  endtask

  // start held high: captures every 11 clocks, each with whatever a/b are
  // present at that edge; results must appear 9 clocks later.
  task automatic test_back_to_back();
    logic [7:0] ra [0:55];
    logic [7:0] rb [0:55];
    int pulses;
    bit exp_done;
    pulses = 0;
    for (int i = 0; i < 56; i++) begin ra[i] = 8'($urandom); rb[i] = 8'($urandom); end
    for (int i = 0; i < 56; i++) begin
      a = ra[i]; b = rb[i]; start = (i < 50);
      tick();  // edge Ei
      exp_done = (i % 11 == 9);
      checks++;
      if (done_flag !== exp_done) begin
        errors++;
        $display("FAIL b2b done@E%0d: done=%b, want %b", i, done_flag, exp_done);
      end
      if (exp_done) begin
        pulses++;
        checks++;
        if (d_out !== 16'(ra[i-9]) * 16'(rb[i-9]) || verif_a !== ra[i-9] || verif_b !== rb[i-9]) begin
          errors++;
          $display("FAIL b2b result@E%0d: d_out=%0d va=%0d vb=%0d, want %0d %0d %0d", i,
                   d_out, verif_a, verif_b, 16'(ra[i-9]) * 16'(rb[i-9]), ra[i-9], rb[i-9]);
        end
        last_prod = 16'(ra[i-9]) * 16'(rb[i-9]);
      end
    end
    start = 1'b0;
    checks++;
    if (pulses != 5) begin
      errors++;
      $display("FAIL b2b pulse_count: %0d, want 5", pulses);
    end
  endtask

  task automatic test_reset_mid_calc();
    int late;
    run_mult(8'd200, 8'd201, 0, "pre_rst");
    a = 8'd99; b = 8'd98; start = 1'b1;
    tick();  // E0
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();  // E1..E4
    rst = 1'b1;
    tick();  // E5
    rst = 1'b0;
    checks++;
    if (locked !== 1'b0 || d_out !== 16'd0 || done_flag !== 1'b0 ||
        verif_a !== 8'd0 || verif_b !== 8'd0) begin
      errors++;
      $display("FAIL mid_rst: locked=%b d_out=%0d done=%b va=%0d vb=%0d, want 0 0 0 0 0",
               locked, d_out, done_flag, verif_a, verif_b);
    end
    late = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done_flag !== 1'b0 || locked !== 1'b0) late++;
    end
    checks++;
    if (late != 0) begin
      errors++;
      $display("FAIL mid_rst_idle: %0d cycles with done/locked set, want 0", late);
    end
    last_prod = 16'd0;
    run_mult(8'd13, 8'd11, 0, "post_rst");
  endtask

  task automatic test_seg_scan();
    logic [7:0] exp;
    int bad;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    last_prod = 16'd0;
    bad = 0;
    exp = 8'h01;
    for (int k = 1; k <= 70; k++) begin
      tick();
      if (k % 4 == 0) exp = {exp[6:0], exp[7]};
      checks++;
      if (seg_position !== exp) begin
        errors++; bad++;
        if (bad < 5) $display("FAIL seg@%0d: seg=%h, want %h", k, seg_position, exp);
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_mid_calc();
    test_seg_scan();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
